dma_ctrl_sched: RTL and testbench

- Avalon-MM slave control/status block that configures and sequences one DMA transfer through the read master and the write master.
- Holds the source address, destination address and byte length.
- Drives a level Start into both masters and watches their sticky done flags to detect completion.
- Raises an optional interrupt on completion, supports software abort and a cycle watchdog.
- Sits between the CPU bus and the RM/WM pair; the FIFO between the masters is outside this block.

---
 rtl/dma_ctrl_sched.sv | 183 ++++++++++++++++++
 tb/tb_dma_ctrl_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl_sched.sv
// DMA control/status slave: holds transfer setup, sequences Start to the
// read/write masters, and reports done, abort and watchdog timeout.
module dma_ctrl_sched #(
   parameter logic        IRQ_EN_RESET   = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        iClk,
   input  logic        iReset_n,
   input  logic        iChipselect,
   input  logic [2:0]  iAddress,
   input  logic        iWrite,
   input  logic [31:0] iWritedata,
   input  logic        iRead,
   output logic [31:0] oReaddata,
   output logic        oIRQ,
   output logic        oStart,
   output logic [31:0] oLength,
   output logic [31:0] oRM_startaddress,
   output logic [31:0] oWM_startaddress,
   input  logic        iRM_done,
   input  logic        iWM_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_CMPL
   } state_t;

   state_t      state, state_n;
   logic [31:0] rdaddr, rdaddr_n;
   logic [31:0] wraddr, wraddr_n;
   logic [31:0] length, length_n;
   logic [31:0] wd_cnt, wd_cnt_n;
   logic        ie, ie_n;
   logic        done, done_n;
   logic        aborted, aborted_n;
   logic        tmo, tmo_n;
   logic        rm_seen, rm_seen_n;
   logic        wm_seen, wm_seen_n;
   logic [31:0] rd_mux;

   logic wr, rd, wr_ctl, go, abort, busy, both_done, wd_hit;

   assign wr        = iChipselect & iWrite;
   assign rd        = iChipselect & iRead;
   assign wr_ctl    = wr & (iAddress == 3'd4);
   assign go        = wr_ctl & iWritedata[0];
   assign abort     = wr_ctl & iWritedata[2];
   assign busy      = (state == S_ARM) | (state == S_RUN);
   assign both_done = (rm_seen | iRM_done) & (wm_seen | iWM_done);
   assign wd_hit    = (TIMEOUT_CYCLES != 0) &&
                      (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

   assign oStart           = busy;
   assign oLength          = length;
   assign oRM_startaddress = rdaddr;
   assign oWM_startaddress = wraddr;

   always_comb begin
      state_n   = state;
      rdaddr_n  = rdaddr;
      wraddr_n  = wraddr;
      length_n  = length;
      wd_cnt_n  = wd_cnt;
      ie_n      = ie;
      done_n    = done;
      aborted_n = aborted;
      tmo_n     = tmo;
      rm_seen_n = rm_seen;
      wm_seen_n = wm_seen;

      if (wr && iAddress == 3'd0) begin
         done_n    = 1'b0;
         aborted_n = 1'b0;
         tmo_n     = 1'b0;
      end
      if (wr_ctl)
         ie_n = iWritedata[1];
      if (wr && !busy) begin
         if (iAddress == 3'd1) rdaddr_n = iWritedata;
         if (iAddress == 3'd2) wraddr_n = iWritedata;
         if (iAddress == 3'd3) length_n = {iWritedata[31:2], 2'b00};
      end

      // Flag updates from the sequencer override a same-cycle STATUS clear.
      unique case (state)
         S_IDLE: begin
            if (go && !abort) begin
               if (length != 32'd0) begin
                  state_n   = S_ARM;
                  done_n    = 1'b0;
                  aborted_n = 1'b0;
                  tmo_n     = 1'b0;
                  rm_seen_n = 1'b0;
                  wm_seen_n = 1'b0;
                  wd_cnt_n  = 32'd0;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         S_ARM: begin
            if (abort) begin
               state_n   = S_IDLE;
               aborted_n = 1'b1;
               done_n    = 1'b0;
            end else begin
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            rm_seen_n = rm_seen | iRM_done;
            wm_seen_n = wm_seen | iWM_done;
            if (abort) begin
               state_n   = S_IDLE;
               aborted_n = 1'b1;
               done_n    = 1'b0;
            end else if (both_done) begin
               state_n = S_CMPL;
            end else if (wd_hit) begin
               state_n   = S_IDLE;
               tmo_n     = 1'b1;
               aborted_n = 1'b1;
            end else begin
               wd_cnt_n = wd_cnt + 32'd1;
            end
         end
         S_CMPL: begin
            done_n  = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 32'd0;
      unique case (iAddress)
         3'd0:    rd_mux = {28'd0, tmo, aborted, busy, done};
         3'd1:    rd_mux = rdaddr;
         3'd2:    rd_mux = wraddr;
         3'd3:    rd_mux = length;
         3'd4:    rd_mux = {30'd0, ie, 1'b0};
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state     <= S_IDLE;
         rdaddr    <= 32'd0;
         wraddr    <= 32'd0;
         length    <= 32'd0;
         wd_cnt    <= 32'd0;
         ie        <= IRQ_EN_RESET;
         done      <= 1'b0;
         aborted   <= 1'b0;
         tmo       <= 1'b0;
         rm_seen   <= 1'b0;
         wm_seen   <= 1'b0;
         oReaddata <= 32'd0;
         oIRQ      <= 1'b0;
      end else begin
         state     <= state_n;
         rdaddr    <= rdaddr_n;
         wraddr    <= wraddr_n;
         length    <= length_n;
         wd_cnt    <= wd_cnt_n;
         ie        <= ie_n;
         done      <= done_n;
         aborted   <= aborted_n;
         tmo       <= tmo_n;
         rm_seen   <= rm_seen_n;
         wm_seen   <= wm_seen_n;
         oIRQ      <= ie_n & (done_n | aborted_n);
         if (rd)
            oReaddata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_dma_ctrl_sched.sv
// Randomized bench for dma_ctrl_sched: each transfer's outcome is predicted
// from its done/abort timing and compared with STATUS, IRQ and Start length.
module tb_dma_ctrl_sched;

   localparam int T = 64;

   logic        iClk = 1'b0;
   logic        iReset_n = 1'b0;
   logic        iChipselect = 1'b0;
   logic [2:0]  iAddress = 3'd0;
   logic        iWrite = 1'b0;
   logic [31:0] iWritedata = 32'd0;
   logic        iRead = 1'b0;
   logic [31:0] oReaddata;
   logic        oIRQ;
   logic        oStart;
   logic [31:0] oLength;
   logic [31:0] oRM_startaddress;
   logic [31:0] oWM_startaddress;
   logic        iRM_done = 1'b0;
   logic        iWM_done = 1'b0;

   int nvec = 0;
   int nerr = 0;

   dma_ctrl_sched #(
      .IRQ_EN_RESET   (1'b1),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .iClk             (iClk),
      .iReset_n         (iReset_n),
      .iChipselect      (iChipselect),
      .iAddress         (iAddress),
      .iWrite           (iWrite),
      .iWritedata       (iWritedata),
      .iRead            (iRead),
      .oReaddata        (oReaddata),
      .oIRQ             (oIRQ),
      .oStart           (oStart),
      .oLength          (oLength),
      .oRM_startaddress (oRM_startaddress),
      .oWM_startaddress (oWM_startaddress),
      .iRM_done         (iRM_done),
      .iWM_done         (iWM_done)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      iChipselect = 1'b0;
      iWrite      = 1'b0;
      iRead       = 1'b0;
      iAddress    = 3'd0;
      iWritedata  = 32'd0;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      iChipselect = 1'b1;
      iWrite      = 1'b1;
      iAddress    = a;
      iWritedata  = d;
      @(posedge iClk); #1;
      bus_idle();
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      iChipselect = 1'b1;
      iRead       = 1'b1;
      iAddress    = a;
      @(posedge iClk); #1;
      bus_idle();
      d = oReaddata;
   endtask

   // Outcome is decided by whichever of abort, completion or watchdog comes
   // first in RUN; abort beats completion, completion beats watchdog.
   task automatic run_xfer(input int dr, input int dw, input int ab,
                           input logic ie);
      logic [31:0] ra, wa, ln, rv;
      int c, runs, st, starts, r;
      ra = $urandom;
      wa = $urandom;
      ln = $urandom | 32'h10;
      c  = (dr > dw) ? dr : dw;
      if (ab >= 0 && ab <= c && ab <= T - 1) begin
         runs = ab + 1; st = 4;
      end else if (c <= T - 1) begin
         runs = c + 1;  st = 1;
      end else begin
         runs = T;      st = 12;
      end

      bus_wr(3'd1, ra);
      bus_wr(3'd2, wa);
      bus_wr(3'd3, ln);
      chk("oLength", oLength, ln & 32'hFFFF_FFFC);
      chk("oRM_addr", oRM_startaddress, ra);
      chk("oWM_addr", oWM_startaddress, wa);

      starts = 0;
      for (int k = 0; k < T + 7; k++) begin
         bus_idle();
         r = k - 2;
         if (k == 0) begin
            iChipselect = 1'b1; iWrite = 1'b1; iAddress = 3'd4;
            iWritedata  = {30'd0, ie, 1'b1};
         end else if (r >= 0) begin
            iRM_done = (r >= dr);
            iWM_done = (r >= dw);
            if (r == ab) begin
               iChipselect = 1'b1; iWrite = 1'b1; iAddress = 3'd4;
               iWritedata  = {29'd0, 1'b1, ie, 1'b0};
            end else if (r < runs - 1 && $urandom_range(0, 3) == 0) begin
               iChipselect = 1'b1; iWrite = 1'b1;
               if ($urandom_range(0, 1) == 0) begin
                  iAddress = 3'd2; iWritedata = 32'hFFFF;
               end else begin
                  iAddress = 3'd4; iWritedata = {30'd0, ie, 1'b1};
               end
            end
         end
         if (oStart) starts++;
         @(posedge iClk); #1;
      end
      bus_idle();

      chk("start_cycles", starts, 1 + runs);
      chk("start_low", oStart, 1'b0);
      bus_rd(3'd0, rv);
      chk("status", rv, st);
      chk("irq", oIRQ, ie);
      bus_rd(3'd2, rv);
      chk("wraddr_kept", rv, wa);
      bus_wr(3'd0, 32'd0);
      chk("irq_clr", oIRQ, 1'b0);
      bus_rd(3'd0, rv);
      chk("status_clr", rv, 32'd0);
   endtask

   initial begin
      logic [31:0] rv;
      int dr, dw, ab;

      repeat (3) @(posedge iClk);
      #1 iReset_n = 1'b1;
      chk("rst_readdata", oReaddata, 32'd0);
      chk("rst_start", oStart, 1'b0);
      chk("rst_irq", oIRQ, 1'b0);
      bus_rd(3'd0, rv);
      chk("rst_status", rv, 32'd0);
      bus_rd(3'd4, rv);
      chk("rst_control", rv, 32'h2);
      for (int a = 5; a < 8; a++) begin
         bus_wr(3'(a), 32'hDEAD_BEEF);
         bus_rd(3'(a), rv);
         chk("unmapped", rv, 32'd0);
      end

      bus_wr(3'd3, 32'h13);
      bus_rd(3'd3, rv);
      chk("len_mask", rv, 32'h10);
      @(posedge iClk); #1;
      chk("rd_hold", oReaddata, 32'h10);

      bus_wr(3'd4, 32'h7);
      chk("go_abort_start", oStart, 1'b0);
      bus_rd(3'd0, rv);
      chk("go_abort_status", rv, 32'd0);

      bus_wr(3'd3, 32'd0);
      bus_wr(3'd4, 32'h3);
      chk("zlen_start", oStart, 1'b0);
      bus_rd(3'd0, rv);
      chk("zlen_status", rv, 32'h1);
      chk("zlen_irq", oIRQ, 1'b1);
      bus_wr(3'd0, 32'd0);

      run_xfer(40, 40, -1, 1'b1);
      run_xfer(3, 9, -1, 1'b1);
      run_xfer(500, 500, 5, 1'b1);
      run_xfer(0, 0, -1, 1'b1);
      run_xfer(500, 500, -1, 1'b1);
      run_xfer(2, 2, 2, 1'b0);
      run_xfer(10, 63, -1, 1'b1);
      for (int i = 0; i < 15; i++) begin
         dr = $urandom_range(0, 90);
         dw = $urandom_range(0, 90);
         ab = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 70));
         run_xfer(dr, dw, ab, 1'($urandom_range(0, 1)));
      end

      iRM_done = 1'b0;
      iWM_done = 1'b0;
      bus_wr(3'd3, 32'h40);
      bus_wr(3'd4, 32'h1);
      repeat (4) @(posedge iClk);
      #2 iReset_n = 1'b0;
      #1 chk("areset_start", oStart, 1'b0);
      @(posedge iClk); #1 iReset_n = 1'b1;
      bus_rd(3'd0, rv);
      chk("areset_status", rv, 32'd0);
      bus_rd(3'd4, rv);
      chk("areset_control", rv, 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
